// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default sizes and the population-count helper used for busy_cnt.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Widest busy vector the popcount helper accepts; callers zero-extend.
  localparam int POP_W = 256;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, flush clears all.
// Priority on one edge: flush > issue > write. Register 0 is never busy.
// With REGFILE_BYPASS_EN defined the post-update busy vector is exported
// so same-edge read bypass can report it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush,
`ifdef REGFILE_BYPASS_EN
  output logic [NREG-1:0] busy_nxt,
`endif
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   busy_cnt
);

`ifndef REGFILE_BYPASS_EN
  logic [NREG-1:0] busy_nxt;
`endif
  logic [POP_W-1:0] pop_vec;
  logic [CW-1:0]    cnt_nxt;

  // Next busy vector: write clears, issue sets (wins), flush clears all.
  always_comb begin
    busy_nxt = busy;
    if (wr_en && (wr_addr != '0)) busy_nxt[wr_addr] = 1'b0;
    if (iss_en && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  // Count of busy bits after this edge's update.
  always_comb begin
    pop_vec             = '0;
    pop_vec[NREG-1:0]   = busy_nxt;
    cnt_nxt             = CW'(popcount(pop_vec));
  end

  // Busy state and its registered count, updated on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD registered read ports, one writeback port and a
// busy scoreboard. All state changes on the falling clock edge; reset is
// asynchronous active-low. Register 0 reads as zero.
// Optional feature: REGFILE_BYPASS_EN forwards a same-edge write to reads
// of the same address (data and post-update busy bit).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [CW-1:0]     busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   rd_idx [NRD];
`ifdef REGFILE_BYPASS_EN
  logic [NREG-1:0] busy_nxt;
  logic [NRD-1:0]  hit;
`endif

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
`ifdef REGFILE_BYPASS_EN
    .busy_nxt (busy_nxt),
`endif
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Split the packed read-address bus into per-port indices.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_idx[k] = rd_addr[k*AW +: AW];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A read hits the bypass when a real write targets the same address.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      hit[k] = wr_en && (wr_addr != '0) && (wr_addr == rd_idx[k]);
    end
  end
`endif

  // Data array: writes to register 0 are dropped so it stays zero.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: register data and busy bit of each addressed register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
        if (hit[k]) begin
          rd_data[k*XLEN +: XLEN] <= wr_data;
          rd_busy[k]              <= busy_nxt[rd_idx[k]];
        end else begin
          rd_data[k*XLEN +: XLEN] <= regs[rd_idx[k]];
          rd_busy[k]              <= busy[rd_idx[k]];
        end
`else
        rd_data[k*XLEN +: XLEN] <= regs[rd_idx[k]];
        rd_busy[k]              <= busy[rd_idx[k]];
`endif
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count, power of two, at least 4.
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of read ports, 1 to 4.
REQ-004 The block SHALL derive local constant AW = $clog2(NREG) for address width and CW = $clog2(NREG+1) for count width.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all state updates on its falling edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port rd_addr, input, width NRD*AW: read addresses, port k at bits [k*AW +: AW].
REQ-008 The block SHALL have port rd_data, output, width NRD*XLEN: registered read data per port.
REQ-009 The block SHALL have port rd_busy, output, width NRD: registered busy flag of each addressed register.
REQ-010 The block SHALL have ports wr_en (input, 1), wr_addr (input, AW) and wr_data (input, XLEN): writeback port.
REQ-011 The block SHALL have ports iss_en (input, 1) and iss_addr (input, AW): issue port that marks a destination pending.
REQ-012 The block SHALL have port flush, input, width 1: clear all busy bits.
REQ-013 The block SHALL have port busy_cnt, output, width CW: registered count of busy registers.

Function
REQ-014 Register 0 SHALL always read 0, never be written and never be busy; wr_en or iss_en to address 0 SHALL be ignored.
REQ-015 On a falling edge with wr_en=1 and wr_addr!=0, regs[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear.
REQ-016 On a falling edge with iss_en=1 and iss_addr!=0, busy[iss_addr] SHALL set; setting an already-busy register SHALL leave it busy.
REQ-017 If issue and write target the same non-zero address on the same edge, data SHALL be written and busy SHALL end set (issue wins).
REQ-018 flush=1 SHALL clear every busy bit on that edge, overriding a same-edge issue; a same-edge write SHALL still update data.
REQ-019 Each read port SHALL register rd_data and rd_busy on every falling edge, latency one edge, with no enable.
REQ-020 busy_cnt SHALL equal the population count of the busy bits after that edge's update, registered on the same edge.
REQ-021 Reads of distinct ports to the same address SHALL return identical values.

Reset
REQ-022 When rst=0, all registers, all busy bits, rd_data, rd_busy and busy_cnt SHALL go to 0 immediately, independent of clk.
REQ-023 Writes or issues presented while rst=0 SHALL be discarded; normal operation SHALL resume on the first falling edge after rst returns to 1.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN defined: on a read of address A where wr_en=1, wr_addr=A and A!=0 on the same edge, rd_data SHALL return wr_data and rd_busy SHALL reflect the post-update busy bit.
REQ-025 Macro REGFILE_BYPASS_EN undefined: rd_data and rd_busy SHALL return pre-edge state, and the write becomes visible one edge later.

Structure
REQ-026 The shared package regfile_pkg SHALL hold the XLEN/NREG defaults and the popcount function used for busy_cnt.
REQ-027 The scoreboard (busy bits, issue/write/flush priority, busy_cnt) SHALL be the sub-module regfile_scoreboard; the data array stays in regfile_sb.

Verification
REQ-028 Reset test: rst=0 mid-run with busy bits set -> all outputs 0 at once, and reads of every address return 0 after release.
REQ-029 Issue/write test: issue x5, then write x5=0xDEADBEEF two edges later -> rd_busy=1 and busy_cnt=1 between those edges, then rd_data=0xDEADBEEF, rd_busy=0 and busy_cnt=0.
REQ-030 Collision test: issue and write x7=0x12345678 on the same edge -> data 0x12345678 and busy[7]=1; flush plus issue x9 on one edge -> busy_cnt=0.
REQ-031 x0 test: wr_en with wr_addr=0 and data 0xFFFFFFFF, plus iss_addr=0 -> reading address 0 returns 0, rd_busy=0 and busy_cnt unchanged.
REQ-032 Bypass test: write x3=0xA5A5A5A5 while reading x3 on the same edge -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value 0 without.
REQ-033 Parameter test: NREG=8, NRD=4, XLEN=16 with all four ports reading different registers after writes -> each port returns its own register and busy_cnt never exceeds 7.
